// File: rtl/pe_net_interface_pkg.sv
// Shared NoC configuration: mesh geometry, timestamp width and the packet payload.
package pe_net_interface_pkg;

  localparam int unsigned X_NODES = 4;
  localparam int unsigned Y_NODES = 4;
  localparam int unsigned NODES   = X_NODES * Y_NODES;
  localparam int unsigned ID_W    = $clog2(NODES);
  localparam int unsigned TS_W    = 16;
  localparam int unsigned DATA_W  = 32;

  typedef struct packed {
    logic [ID_W-1:0]   source;
    logic [ID_W-1:0]   dest;
    logic [TS_W-1:0]   timestamp;
    logic [DATA_W-1:0] data;
  } packet_t;

  // The router's free-slot count lags one cycle, so a single slot is only safe if we did not just inject.
  function automatic logic credit_ok(input logic [3:0] en, input logic inj);
    return (en >= 4'd2) || ((en == 4'd1) && !inj);
  endfunction

endpackage

// File: rtl/pe_net_interface_fifo.sv
// Synchronous packet FIFO with pointer-wrap full/empty detection; no bypass path.
module pkt_fifo
  import pe_net_interface_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  packet_t i_data,
  input  logic    i_pop,
  output packet_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  packet_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pe_net_interface.sv
// PE-to-router local-port adapter: credit-gated TX injection from a FIFO, registered RX with statistics.
module pe_net_interface
  import pe_net_interface_pkg::*;
#(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  packet_t          i_pe_pkt,
  input  logic             i_pe_valid,
  output logic             o_pe_ready,
  output packet_t          o_net_data,
  output logic             o_net_data_val,
  input  logic [3:0]       i_net_en,
  input  packet_t          i_net_data,
  input  logic             i_net_data_val,
  output packet_t          o_rx_pkt,
  output logic             o_rx_valid,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_lat_sum,
  output logic             o_misroute
);

  logic [TS_W-1:0]  r_cycle;
  logic             r_inj;
  logic [CNT_W-1:0] r_tx_count;
  logic [CNT_W-1:0] r_rx_count;
  logic [CNT_W-1:0] r_lat_sum;
  logic             r_misroute;
  logic             r_rx_valid;
  packet_t          r_rx_pkt;

  packet_t          w_push_pkt;
  packet_t          w_head;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [TS_W-1:0]  w_lat;

  assign o_pe_ready     = !w_full && !reset;
  assign w_push         = i_pe_valid && o_pe_ready;
  assign o_net_data_val = !w_empty && credit_ok(i_net_en, r_inj);
  assign w_lat          = r_cycle - i_net_data.timestamp;

  assign o_tx_count = r_tx_count;
  assign o_rx_count = r_rx_count;
  assign o_lat_sum  = r_lat_sum;
  assign o_misroute = r_misroute;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_pkt   = r_rx_pkt;

  // Source is stamped on entry, injection time on exit.
  always_comb begin
    w_push_pkt        = i_pe_pkt;
    w_push_pkt.source = ID_W'(NODE_ID);
    o_net_data        = '0;
    if (o_net_data_val) begin
      o_net_data           = w_head;
      o_net_data.timestamp = r_cycle;
    end
  end

  pkt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_pkt),
    .i_pop   (o_net_data_val),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle    <= '0;
      r_inj      <= 1'b0;
      r_tx_count <= '0;
    end else begin
      r_cycle <= r_cycle + TS_W'(1);
      r_inj   <= o_net_data_val;
      if (o_net_data_val) r_tx_count <= r_tx_count + CNT_W'(1);
    end
  end

  // Misrouted packets are still counted; the flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_pkt   <= '0;
      r_rx_valid <= 1'b0;
      r_rx_count <= '0;
      r_lat_sum  <= '0;
      r_misroute <= 1'b0;
    end else begin
      r_rx_valid <= i_net_data_val;
      if (i_net_data_val) begin
        r_rx_pkt   <= i_net_data;
        r_rx_count <= r_rx_count + CNT_W'(1);
        r_lat_sum  <= r_lat_sum + CNT_W'(w_lat);
        if (i_net_data.dest != ID_W'(NODE_ID)) r_misroute <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_net_interface.sv
// Directed bench for pe_net_interface with a TX/RX scoreboard checked every cycle.
module tb_pe_net_interface;
  import pe_net_interface_pkg::*;

  localparam int unsigned NODE_ID = 0;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNT_W   = 32;

  logic             clk;
  logic             reset;
  packet_t          i_pe_pkt;
  logic             i_pe_valid;
  logic             o_pe_ready;
  packet_t          o_net_data;
  logic             o_net_data_val;
  logic [3:0]       i_net_en;
  packet_t          i_net_data;
  logic             i_net_data_val;
  packet_t          o_rx_pkt;
  logic             o_rx_valid;
  logic [CNT_W-1:0] o_tx_count;
  logic [CNT_W-1:0] o_rx_count;
  logic [CNT_W-1:0] o_lat_sum;
  logic             o_misroute;

  pe_net_interface #(.NODE_ID(NODE_ID), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pe_pkt       (i_pe_pkt),
    .i_pe_valid     (i_pe_valid),
    .o_pe_ready     (o_pe_ready),
    .o_net_data     (o_net_data),
    .o_net_data_val (o_net_data_val),
    .i_net_en       (i_net_en),
    .i_net_data     (i_net_data),
    .i_net_data_val (i_net_data_val),
    .o_rx_pkt       (o_rx_pkt),
    .o_rx_valid     (o_rx_valid),
    .o_tx_count     (o_tx_count),
    .o_rx_count     (o_rx_count),
    .o_lat_sum      (o_lat_sum),
    .o_misroute     (o_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_cmp;
  int               n_err;
  packet_t          tx_q [$];
  packet_t          rx_q [$];
  logic [TS_W-1:0]  tb_cycle;
  logic             tb_inj;
  logic [31:0]      val_hist;
  logic [31:0]      rdy_hist;
  logic [CNT_W-1:0] exp_tx;
  logic [CNT_W-1:0] exp_rx;
  logic [CNT_W-1:0] exp_lat;
  logic             exp_mis;

  function automatic packet_t mk_pkt(input int src, input int dst, input int ts, input int dat);
    packet_t p;
    p.source    = ID_W'(src);
    p.dest      = ID_W'(dst);
    p.timestamp = TS_W'(ts);
    p.data      = DATA_W'(dat);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    tx_q.delete();
    rx_q.delete();
    tb_cycle = '0;
    tb_inj   = 1'b0;
    exp_tx   = '0;
    exp_rx   = '0;
    exp_lat  = '0;
    exp_mis  = 1'b0;
  endtask

  // Called at posedge+1 with this cycle's inputs already driven.
  task automatic tick();
    logic    exp_rdy;
    logic    exp_val;
    logic    cred;
    packet_t p;
    #2;
    cred    = (i_net_en > 4'd1) || (i_net_en == 4'd1 && tb_inj == 1'b0);
    exp_rdy = !reset && (tx_q.size() < DEPTH);
    exp_val = !reset && (tx_q.size() > 0) && cred;
    chk("pe_ready", 64'(o_pe_ready), 64'(exp_rdy));
    chk("net_val", 64'(o_net_data_val), 64'(exp_val));
    val_hist = {val_hist[30:0], o_net_data_val};
    rdy_hist = {rdy_hist[30:0], o_pe_ready};
    if (exp_val) begin
      p = tx_q.pop_front();
      p.timestamp = tb_cycle;
      chk("net_data", 64'(o_net_data), 64'(p));
      exp_tx = exp_tx + 1;
    end else begin
      chk("net_data_idle", 64'(o_net_data), 64'(0));
    end
    if (i_pe_valid && exp_rdy) begin
      p = i_pe_pkt;
      p.source = ID_W'(NODE_ID);
      tx_q.push_back(p);
    end
    if (i_net_data_val && !reset) begin
      rx_q.push_back(i_net_data);
      exp_rx  = exp_rx + 1;
      exp_lat = exp_lat + CNT_W'(TS_W'(tb_cycle - i_net_data.timestamp));
      if (i_net_data.dest != ID_W'(NODE_ID)) exp_mis = 1'b1;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      tb_cycle = '0;
      tb_inj   = 1'b0;
    end else begin
      tb_cycle = tb_cycle + 1'b1;
      tb_inj   = exp_val;
    end
    if (rx_q.size() > 0) begin
      chk("rx_valid", 64'(o_rx_valid), 64'(1));
      p = rx_q.pop_front();
      chk("rx_pkt", 64'(o_rx_pkt), 64'(p));
    end else begin
      chk("rx_valid_idle", 64'(o_rx_valid), 64'(0));
    end
    chk("tx_count", 64'(o_tx_count), 64'(exp_tx));
    chk("rx_count", 64'(o_rx_count), 64'(exp_rx));
    chk("lat_sum", 64'(o_lat_sum), 64'(exp_lat));
    chk("misroute", 64'(o_misroute), 64'(exp_mis));
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    val_hist       = '0;
    rdy_hist       = '0;
    reset          = 1'b1;
    i_pe_pkt       = '0;
    i_pe_valid     = 1'b0;
    i_net_en       = 4'd0;
    i_net_data     = '0;
    i_net_data_val = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    tick();
    chk("reset_rx_pkt", 64'(o_rx_pkt), 64'(0));
    reset = 1'b0;

    // Latency across timestamp wrap: cycle 3, stamp 65533.
    while (tb_cycle != 16'd3) tick();
    i_net_data     = mk_pkt(5, NODE_ID, 65533, 32'h1111);
    i_net_data_val = 1'b1;
    tick();
    i_net_data_val = 1'b0;
    chk("lat_wrap", 64'(o_lat_sum), 64'(6));

    // Four pushes at full credit: injections on cycles 1..4 after the first push.
    i_net_en = 4'd4;
    val_hist = '0;
    for (int i = 0; i < 4; i++) begin
      i_pe_pkt   = mk_pkt(10, 3, 0, 32'hA000 + i);
      i_pe_valid = 1'b1;
      tick();
    end
    i_pe_valid = 1'b0;
    tick();
    tick();
    chk("t1_val_pattern", 64'(val_hist[5:0]), 64'(6'b011110));
    chk("t1_tx_count", 64'(o_tx_count), 64'(4));

    // Single credit: alternate cycles only.
    i_net_en = 4'd0;
    for (int i = 0; i < 4; i++) begin
      i_pe_pkt   = mk_pkt(7, 9, 0, 32'hB000 + i);
      i_pe_valid = 1'b1;
      tick();
    end
    i_pe_valid = 1'b0;
    i_net_en   = 4'd1;
    val_hist   = '0;
    for (int i = 0; i < 7; i++) tick();
    chk("t2_val_pattern", 64'(val_hist[6:0]), 64'(7'b1010101));

    // No credit: FIFO fills at DEPTH, then drains at peak rate.
    i_net_en = 4'd0;
    rdy_hist = '0;
    for (int i = 0; i < 10; i++) begin
      i_pe_pkt   = mk_pkt(1, 2, 0, 32'hC000 + i);
      i_pe_valid = 1'b1;
      tick();
    end
    i_pe_valid = 1'b0;
    chk("t3_ready_pattern", 64'(rdy_hist[9:0]), 64'(10'b1111111100));
    i_net_en = 4'd15;
    val_hist = '0;
    for (int i = 0; i < 9; i++) tick();
    chk("t3_drain_pattern", 64'(val_hist[8:0]), 64'(9'b111111110));
    chk("t3_tx_count", 64'(o_tx_count), 64'(16));

    // Receive at cycle 100 with stamp 90.
    for (int i = 0; i < 300 && tb_cycle != 16'd100; i++) tick();
    i_net_data     = mk_pkt(4, NODE_ID, 90, 32'h2222);
    i_net_data_val = 1'b1;
    tick();
    i_net_data_val = 1'b0;
    chk("lat_100_90", 64'(o_lat_sum), 64'(16));
    tick();

    // Misrouted packet while injecting in the same cycle.
    i_net_en       = 4'd4;
    i_pe_pkt       = mk_pkt(0, 6, 0, 32'hD00D);
    i_pe_valid     = 1'b1;
    i_net_data     = mk_pkt(2, NODE_ID + 1, 95, 32'h3333);
    i_net_data_val = 1'b1;
    tick();
    i_pe_valid     = 1'b0;
    i_net_data     = mk_pkt(3, NODE_ID, 100, 32'h4444);
    tick();
    i_net_data_val = 1'b0;
    tick();
    chk("misroute_sticky", 64'(o_misroute), 64'(1));
    chk("rx_count_after_mis", 64'(o_rx_count), 64'(4));

    // Reset with five packets queued.
    i_net_en = 4'd0;
    for (int i = 0; i < 5; i++) begin
      i_pe_pkt   = mk_pkt(8, 8, 0, 32'hE000 + i);
      i_pe_valid = 1'b1;
      tick();
    end
    i_pe_valid = 1'b0;
    i_net_en   = 4'd15;
    reset      = 1'b1;
    #1;
    chk("rst_net_val", 64'(o_net_data_val), 64'(0));
    chk("rst_pe_ready", 64'(o_pe_ready), 64'(0));
    chk("rst_tx_count", 64'(o_tx_count), 64'(0));
    chk("rst_rx_count", 64'(o_rx_count), 64'(0));
    chk("rst_lat_sum", 64'(o_lat_sum), 64'(0));
    chk("rst_misroute", 64'(o_misroute), 64'(0));
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    tick();
    i_pe_pkt   = mk_pkt(9, 1, 0, 32'hF00D);
    i_pe_valid = 1'b1;
    tick();
    i_pe_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_tx_count", 64'(o_tx_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
